// File: rtl/mc_pkg.sv
// Shared encodings for the handshaked multicycle datapath: ALU operations,
// immediate formats, operand/result selects and the memory-access FSM state.
package mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } aluop_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_AREG  = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_BREG = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10,
    SRCB_ZERO = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_ALU    = 2'b01,
    RES_MDR    = 2'b10,
    RES_IMM    = 2'b11
  } ressrc_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_REQ  = 2'b01,
    MEM_DONE = 2'b10
  } memst_e;

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// entry 0 hardwired to zero (never written, always reads zero).
module mc_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [XLEN-1:0]          wd,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2
);

  logic [XLEN-1:0] regs [NREGS];

  // Register storage; writes aimed at index 0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports with index 0 forced to zero.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
  end

endmodule

// File: rtl/mc_datapath_hs.sv
// Parametrised multicycle RISC-V datapath with a valid/ready memory port.
// A small FSM owns the bus so the controller can tolerate memory wait states.
module mc_datapath_hs
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcen,
  input  logic            adrsrc,
  input  logic            memreq,
  input  logic            memwrite,
  input  logic            irwrite,
  input  logic            regwrite,
  input  logic [1:0]      alusrca,
  input  logic [1:0]      alusrcb,
  input  logic [2:0]      aluop,
  input  logic [1:0]      resultsrc,
  input  logic [2:0]      immsrc,
  output logic            memdone,
  output logic            membusy,
  output logic            zer,
  output logic            neg,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_valid,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);

  memst_e          state;
  logic            irw_q;
  logic [XLEN-1:0] pc, oldpc, mdr, a_reg, b_reg, alu_out;
  logic [31:0]     ir;
  logic [XLEN-1:0] rd1, rd2, imm, src_a, src_b, alu_res, result;
  logic            rd_complete;

  assign opcode = ir[6:0];
  assign func3  = ir[14:12];
  assign func7  = ir[31:25];

  // A read finishes on the REQ edge that sees mem_ready with a non-write access.
  assign rd_complete = (state == MEM_REQ) && mem_ready && !mem_we;

  mc_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (regwrite),
    .ra1 (ir[15 +: RW]),
    .ra2 (ir[20 +: RW]),
    .wa  (ir[7 +: RW]),
    .wd  (result),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // Immediate decode, every format sign-extended to XLEN.
  always_comb begin
    imm = '0;
    case (immsrc_e'(immsrc))
      IMM_I:   imm = XLEN'($signed(ir[31:20]));
      IMM_S:   imm = XLEN'($signed({ir[31:25], ir[11:7]}));
      IMM_B:   imm = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      IMM_J:   imm = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      IMM_U:   imm = XLEN'($signed({ir[31:12], 12'b0}));
      default: imm = '0;
    endcase
  end

  // ALU operand selection.
  always_comb begin
    src_a = '0;
    case (srca_e'(alusrca))
      SRCA_PC:    src_a = pc;
      SRCA_OLDPC: src_a = oldpc;
      SRCA_AREG:  src_a = a_reg;
      SRCA_ZERO:  src_a = '0;
      default:    src_a = '0;
    endcase
    src_b = '0;
    case (srcb_e'(alusrcb))
      SRCB_BREG: src_b = b_reg;
      SRCB_IMM:  src_b = imm;
      SRCB_FOUR: src_b = XLEN'(4);
      SRCB_ZERO: src_b = '0;
      default:   src_b = '0;
    endcase
  end

  // Combinational ALU.
  always_comb begin
    alu_res = '0;
    case (aluop_e'(aluop))
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_SLT:  alu_res[0] = $signed(src_a) < $signed(src_b);
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLTU: alu_res[0] = src_a < src_b;
      ALU_SLL:  alu_res = src_a << src_b[SW-1:0];
      default:  alu_res = '0;
    endcase
  end

  assign zer = (alu_res == '0);
  assign neg = alu_res[XLEN-1];

  // Result bus selection.
  always_comb begin
    result = '0;
    case (ressrc_e'(resultsrc))
      RES_ALUOUT: result = alu_out;
      RES_ALU:    result = alu_res;
      RES_MDR:    result = mdr;
      RES_IMM:    result = imm;
      default:    result = '0;
    endcase
  end

  // Architectural and pipeline registers; IR/OLDPC/MDR only move on read completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      oldpc   <= '0;
      mdr     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      a_reg   <= rd1;
      b_reg   <= rd2;
      alu_out <= alu_res;
      if (pcen) pc <= result;
      if (rd_complete) begin
        mdr <= mem_rdata;
        if (irw_q) begin
          ir    <= mem_rdata[31:0];
          oldpc <= pc;
        end
      end
    end
  end

  // Memory-access FSM with registered bus outputs; accepts a new request in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MEM_IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      membusy   <= 1'b0;
      memdone   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      irw_q     <= 1'b0;
    end else begin
      memdone <= 1'b0;
      case (state)
        MEM_IDLE, MEM_DONE: begin
          if (memreq) begin
            state     <= MEM_REQ;
            mem_addr  <= adrsrc ? result : pc;
            mem_wdata <= b_reg;
            mem_we    <= memwrite;
            irw_q     <= irwrite;
            mem_valid <= 1'b1;
            membusy   <= 1'b1;
          end else begin
            state <= MEM_IDLE;
          end
        end
        MEM_REQ: begin
          if (mem_ready) begin
            state     <= MEM_DONE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            membusy   <= 1'b0;
            memdone   <= 1'b1;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs (XLEN=32, NREGS=32, RESET_PC=0x100).
module tb_mc_datapath_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcen, adrsrc, memreq, memwrite, irwrite, regwrite;
  logic [1:0]  alusrca, alusrcb, resultsrc;
  logic [2:0]  aluop, immsrc;
  logic        memdone, membusy, zer, neg;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_valid, mem_ready;

  int n_vec = 0;
  int n_err = 0;

  mc_datapath_hs #(
    .XLEN     (32),
    .NREGS    (32),
    .RESET_PC (32'h100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pcen      (pcen),
    .adrsrc    (adrsrc),
    .memreq    (memreq),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .resultsrc (resultsrc),
    .immsrc    (immsrc),
    .memdone   (memdone),
    .membusy   (membusy),
    .zer       (zer),
    .neg       (neg),
    .opcode    (opcode),
    .func3     (func3),
    .func7     (func7),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait access; memdone must follow memreq by two edges.
  task automatic mem_access(input logic we, input logic irw, input logic asrc,
                            input logic [31:0] rdata);
    int lat;
    memreq = 1'b1; memwrite = we; irwrite = irw; adrsrc = asrc;
    mem_rdata = rdata; mem_ready = 1'b1;
    tick();
    memreq = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
    lat = 1;
    while (memdone !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    check("acc_lat", 64'(lat), 64'd2);
    mem_ready = 1'b0;
  endtask

  initial begin
    int          dones;
    logic [31:0] acc;

    rst = 1'b0;
    pcen = 0; adrsrc = 0; memreq = 0; memwrite = 0; irwrite = 0; regwrite = 0;
    alusrca = 0; alusrcb = 0; aluop = 0; resultsrc = 0; immsrc = 0;
    mem_ready = 0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_pc", dut.pc, 32'h100);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_done", memdone, 1'b0);
    check("rst_busy", membusy, 1'b0);
    check("rst_we", mem_we, 1'b0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.u_rf.regs[i];
    check("rst_regs", acc, 32'h0);

    // Zero-wait fetch of addi x1,x0,5
    mem_rdata = 32'h0050_0093; mem_ready = 1'b1;
    memreq = 1'b1; irwrite = 1'b1; adrsrc = 1'b0;
    tick();
    memreq = 1'b0; irwrite = 1'b0;
    check("f0_valid", mem_valid, 1'b1);
    check("f0_addr", mem_addr, 32'h100);
    check("f0_done_early", memdone, 1'b0);
    tick();
    check("f0_done", memdone, 1'b1);
    check("f0_busy", membusy, 1'b0);
    check("f0_opcode", opcode, 7'h13);
    check("f0_func3", func3, 3'h0);
    check("f0_oldpc", dut.oldpc, 32'h100);
    tick();
    check("f0_done_pulse", memdone, 1'b0);
    mem_ready = 1'b0;

    // PC <- PC + 4, then OLDPC through the ALU
    alusrca = 2'b00; alusrcb = 2'b10; aluop = 3'b000; resultsrc = 2'b01; pcen = 1'b1;
    tick();
    pcen = 1'b0;
    check("pc_inc", dut.pc, 32'h104);
    alusrca = 2'b01; alusrcb = 2'b11;
    #1;
    check("oldpc_alu", dut.alu_res, 32'h100);

    // Fetch with three wait states; a memreq pulse during REQ must be ignored
    mem_rdata = 32'h0050_0093; mem_ready = 1'b0;
    memreq = 1'b1; irwrite = 1'b1; adrsrc = 1'b0;
    tick();
    memreq = 1'b0; irwrite = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      check("ws_valid", mem_valid, 1'b1);
      check("ws_addr", mem_addr, 32'h104);
      dones += int'(memdone);
      memreq = (i == 1); adrsrc = (i == 1);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    memreq = 1'b0; adrsrc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dones += int'(memdone);
      tick();
      mem_ready = 1'b0;
    end
    check("ws_done_once", 64'(dones), 64'd1);
    check("ws_idle_after", mem_valid, 1'b0);
    check("ws_oldpc", dut.oldpc, 32'h104);

    // Execute addi x1,x0,5 through ALUOut
    alusrca = 2'b10; alusrcb = 2'b01; aluop = 3'b000; immsrc = 3'b000; resultsrc = 2'b00;
    tick();
    regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
    check("x1_addi", dut.u_rf.regs[1], 32'd5);

    // addi x0,x0,7: write of the immediate to x0 is dropped
    mem_access(1'b0, 1'b1, 1'b0, 32'h0070_0013);
    resultsrc = 2'b11; regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
    check("x0_zero", dut.u_rf.regs[0], 32'h0);
    check("x1_kept", dut.u_rf.regs[1], 32'd5);

    // Load 0xDEADBEEF into x2 via MDR (read without irwrite leaves IR alone)
    mem_access(1'b0, 1'b1, 1'b0, 32'h0000_0113);
    mem_access(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    check("mdr_load", dut.mdr, 32'hDEAD_BEEF);
    check("ir_kept_rd", dut.ir, 32'h0000_0113);
    resultsrc = 2'b10; regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
    check("x2_mdr", dut.u_rf.regs[2], 32'hDEAD_BEEF);

    // sw x2,0x200(x0)
    mem_access(1'b0, 1'b1, 1'b0, 32'h2020_2023);
    alusrca = 2'b10; alusrcb = 2'b01; immsrc = 3'b001; aluop = 3'b000; resultsrc = 2'b01;
    tick();
    mem_rdata = 32'h1234_5678; mem_ready = 1'b0;
    memreq = 1'b1; memwrite = 1'b1; adrsrc = 1'b1;
    tick();
    memreq = 1'b0; memwrite = 1'b0; adrsrc = 1'b0;
    check("st_we", mem_we, 1'b1);
    check("st_addr", mem_addr, 32'h200);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_valid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("st_done", memdone, 1'b1);
    check("st_mdr_kept", dut.mdr, 32'h2020_2023);
    check("st_ir_kept", dut.ir, 32'h2020_2023);

    // addi x0,x1,5: A=5, imm=5
    mem_access(1'b0, 1'b1, 1'b0, 32'h0050_8013);
    tick();
    alusrca = 2'b10; alusrcb = 2'b01; immsrc = 3'b000; aluop = 3'b001;
    #1;
    check("sub_res", dut.alu_res, 32'h0);
    check("sub_zer", zer, 1'b1);
    aluop = 3'b111;
    #1;
    check("sll_res", dut.alu_res, 32'h0000_00A0);
    check("sll_zer", zer, 1'b0);
    alusrca = 2'b11; aluop = 3'b000; immsrc = 3'b100;
    #1;
    check("imm_u", dut.alu_res, 32'h0050_8000);
    immsrc = 3'b011;
    #1;
    check("imm_j", dut.alu_res, 32'h0000_8804);

    // PC = 0x7FFFFFFC, PC + 4 overflows into the sign bit
    mem_access(1'b0, 1'b0, 1'b0, 32'h7FFF_FFFC);
    resultsrc = 2'b10; pcen = 1'b1;
    tick();
    pcen = 1'b0;
    check("pc_from_mdr", dut.pc, 32'h7FFF_FFFC);
    alusrca = 2'b00; alusrcb = 2'b10; aluop = 3'b000;
    #1;
    check("ovf_res", dut.alu_res, 32'h8000_0000);
    check("ovf_neg", neg, 1'b1);
    check("ovf_zer", zer, 1'b0);

    // PC = -1 against imm 5
    mem_access(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    resultsrc = 2'b10; pcen = 1'b1;
    tick();
    pcen = 1'b0;
    alusrca = 2'b00; alusrcb = 2'b01; immsrc = 3'b000; aluop = 3'b100;
    #1;
    check("slt_neg", dut.alu_res, 32'h1);
    aluop = 3'b110;
    #1;
    check("sltu_big", dut.alu_res, 32'h0);
    aluop = 3'b101;
    #1;
    check("xor_res", dut.alu_res, 32'hFFFF_FFFA);
    aluop = 3'b010;
    #1;
    check("and_res", dut.alu_res, 32'h0000_0005);
    aluop = 3'b011;
    #1;
    check("or_res", dut.alu_res, 32'hFFFF_FFFF);
    alusrcb = 2'b10; aluop = 3'b000;
    #1;
    check("add_wrap", dut.alu_res, 32'h0000_0003);

    // addi x0,x1,-1: negative I and B immediates
    mem_access(1'b0, 1'b1, 1'b0, 32'hFFF0_8013);
    tick();
    alusrca = 2'b10; alusrcb = 2'b01; immsrc = 3'b000; aluop = 3'b000;
    #1;
    check("imm_i_neg", dut.alu_res, 32'h0000_0004);
    alusrca = 2'b11; immsrc = 3'b010;
    #1;
    check("imm_b_neg", dut.alu_res, 32'hFFFF_F7E0);

    // Asynchronous reset while a request is outstanding
    mem_ready = 1'b0;
    memreq = 1'b1; adrsrc = 1'b0;
    tick();
    memreq = 1'b0;
    check("ar_valid_pre", mem_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", mem_valid, 1'b0);
    check("ar_busy", membusy, 1'b0);
    check("ar_pc", dut.pc, 32'h100);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ar_idle", mem_valid, 1'b0);
    check("ar_nodone", memdone, 1'b0);
    mem_access(1'b0, 1'b1, 1'b0, 32'h0050_0093);
    check("ar_refetch", opcode, 7'h13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
